// File: rtl/fir3_pkg.sv
// Shared types and constants for the three-tap serial-MAC FIR datapath.
package fir3_pkg;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 16;

  localparam logic [ACC_W-1:0] SAT_VAL = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    ACC2 = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Operands are zero-extended first; DATA_W + COEF_W == ACC_W so the product never truncates.
  function automatic logic [ACC_W-1:0] tap_product(input logic [COEF_W-1:0] c,
                                                   input logic [DATA_W-1:0] x);
    logic [ACC_W-1:0] ce;
    logic [ACC_W-1:0] xe;
    ce = ACC_W'(c);
    xe = ACC_W'(x);
    return ce * xe;
  endfunction

endpackage

// File: rtl/fir3_serial_mac_if.sv
// Sample-in / result-out handshake bundle; master is the sample source and consumer, slave is the filter.
interface fir3_serial_mac_if #(
  parameter int DATA_W = fir3_pkg::DATA_W,
  parameter int COEF_W = fir3_pkg::COEF_W,
  parameter int ACC_W  = fir3_pkg::ACC_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sample;
  logic [COEF_W-1:0] coef0;
  logic [COEF_W-1:0] coef1;
  logic [COEF_W-1:0] coef2;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_y;
  logic              out_ovf;

  modport master (
    output in_valid, in_sample, coef0, coef1, coef2, out_ready,
    input  in_ready, out_valid, out_y, out_ovf
  );

  modport slave (
    input  in_valid, in_sample, coef0, coef1, coef2, out_ready,
    output in_ready, out_valid, out_y, out_ovf
  );

endinterface

// File: rtl/fir3_serial_mac_csa.sv
// 16-bit carry-skip adder: 4-bit ripple blocks whose carry-in bypasses a block when every bit propagates.
module carryskipadder
  import fir3_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  localparam int BLK  = 4;
  localparam int NBLK = ACC_W / BLK;

  logic           c_blk;
  logic           p_blk;
  logic           c_rip;
  logic [BLK-1:0] s_blk;

  always_comb begin
    c_blk = 1'b0;
    p_blk = 1'b0;
    c_rip = 1'b0;
    s_blk = '0;
    sum   = '0;
    for (int k = 0; k < NBLK; k++) begin
      p_blk = &(a[k*BLK +: BLK] ^ b[k*BLK +: BLK]);
      {c_rip, s_blk} = {1'b0, a[k*BLK +: BLK]} + {1'b0, b[k*BLK +: BLK]} + {{BLK{1'b0}}, c_blk};
      sum[k*BLK +: BLK] = s_blk;
      // A fully propagating block passes its carry-in straight through.
      c_blk = p_blk ? c_blk : c_rip;
    end
    carry = c_blk;
  end

endmodule

// File: rtl/fir3_serial_mac.sv
// 3-tap FIR, one shared adder over ACC0..ACC2; out_valid 3 cycles after accept, result held in OUT until out_ready.
// FIR3_OVF_SAT_EN: saturate the accumulator to 16'hFFFF on the first carry of a sample instead of wrapping.
module fir3_serial_mac
  import fir3_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fir3_serial_mac_if.slave    bus
);

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] x0_q, x1_q, x2_q;
  logic [COEF_W-1:0] c0_q, c1_q, c2_q;
  logic [ACC_W-1:0]  acc_q;
  logic              ovf_q;

  logic              accept;
  logic              acc_en;
  logic              in_ready_c;
  logic              out_valid_c;

  logic [COEF_W-1:0] c_sel;
  logic [DATA_W-1:0] x_sel;
  logic [ACC_W-1:0]  product;
  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    acc_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ACC0;
        end
      end
      ACC0: begin
        acc_en  = 1'b1;
        state_d = ACC1;
      end
      ACC1: begin
        acc_en  = 1'b1;
        state_d = ACC2;
      end
      ACC2: begin
        acc_en  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tap select for the shared adder; outside ACC1/ACC2 tap 0 is presented harmlessly.
  always_comb begin
    c_sel = c0_q;
    x_sel = x0_q;
    case (state_q)
      ACC1: begin
        c_sel = c1_q;
        x_sel = x1_q;
      end
      ACC2: begin
        c_sel = c2_q;
        x_sel = x2_q;
      end
      default: begin
        c_sel = c0_q;
        x_sel = x0_q;
      end
    endcase
    product = tap_product(c_sel, x_sel);
  end

  carryskipadder u_add (
    .a     (acc_q),
    .b     (product),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q  <= '0;
      x1_q  <= '0;
      x2_q  <= '0;
      c0_q  <= '0;
      c1_q  <= '0;
      c2_q  <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      x2_q  <= x1_q;
      x1_q  <= x0_q;
      x0_q  <= bus.in_sample;
      c0_q  <= bus.coef0;
      c1_q  <= bus.coef1;
      c2_q  <= bus.coef2;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (acc_en) begin
      ovf_q <= ovf_q | add_carry;
`ifdef FIR3_OVF_SAT_EN
      // Once saturated, stay pinned for the remaining taps of this sample.
      acc_q <= (ovf_q | add_carry) ? SAT_VAL : add_sum;
`else
      acc_q <= add_sum;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_y     = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_fir3_serial_mac.sv
// Scoreboard bench for fir3_serial_mac: directed samples push expected results, a negedge monitor checks them.
module tb_fir3_serial_mac;
  import fir3_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir3_serial_mac_if ifc ();

  fir3_serial_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

`ifdef FIR3_OVF_SAT_EN
  localparam logic [15:0] OVF_Y2 = 16'hFFFF;
  localparam logic [15:0] OVF_Y3 = 16'hFFFF;
`else
  localparam logic [15:0] OVF_Y2 = 16'hFC02;
  localparam logic [15:0] OVF_Y3 = 16'hFA03;
`endif

  typedef struct {
    logic [15:0] y;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];

  int   cyc         = 0;
  int   checks      = 0;
  int   passed      = 0;
  int   last_acc    = 0;
  int   valid_start = 0;
  logic prev_valid  = 1'b0;
  bit   b2b         = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: compares on every handshake, and checks hold behaviour under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (ifc.out_valid && !prev_valid) valid_start = cyc;
      if (ifc.out_valid) begin
        if (q.size() != 1) begin
          chk("queue_depth", q.size(), 1);
        end else if (!ifc.out_ready) begin
          chk("hold_y", ifc.out_y, q[0].y);
          chk("hold_in_ready", ifc.in_ready, 0);
        end else begin
          chk("out_y", ifc.out_y, q[0].y);
          chk("out_ovf", ifc.out_ovf, q[0].ovf);
          chk("latency", valid_start - q[0].acc_cyc, 3);
          void'(q.pop_front());
        end
      end
      prev_valid = ifc.out_valid;
    end
  end

  task automatic send(input logic [7:0] s, input logic [7:0] c0, input logic [7:0] c1,
                      input logic [7:0] c2, input logic [15:0] ey, input logic eovf, input bit push);
    int n;
    n = 0;
    ifc.in_valid  = 1'b1;
    ifc.in_sample = s;
    ifc.coef0     = c0;
    ifc.coef1     = c1;
    ifc.coef2     = c2;
    @(negedge clk);
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      fail_now("accept");
      ifc.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (push) q.push_back('{ey, eovf, cyc});
      if (b2b) chk("accept_spacing", cyc - last_acc, 5);
      last_acc     = cyc;
      ifc.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      fail_now("drain");
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_y", ifc.out_y, 0);
    chk("rst_out_ovf", ifc.out_ovf, 0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    fail_now("watchdog");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    int n;
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_sample = '0;
    ifc.coef0     = '0;
    ifc.coef1     = '0;
    ifc.coef2     = '0;
    ifc.out_ready = 1'b1;
    do_reset();

    // Zero history, then the delay line fills.
    send(8'd10, 8'd1, 8'd2, 8'd3, 16'd10, 1'b0, 1'b1);
    send(8'd20, 8'd1, 8'd2, 8'd3, 16'd40, 1'b0, 1'b1);
    send(8'd30, 8'd1, 8'd2, 8'd3, 16'd100, 1'b0, 1'b1);
    drain();

    // Backpressure: hold OUT five cycles while in_valid pulses are offered.
    ifc.out_ready = 1'b0;
    send(8'd40, 8'd1, 8'd2, 8'd3, 16'd160, 1'b0, 1'b1);
    n = 0;
    while (!ifc.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ifc.out_valid) fail_now("wait_out_valid");
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid  = (i % 2 == 0);
      ifc.in_sample = 8'd99;
      ifc.coef0     = 8'd7;
      @(posedge clk);
      #1;
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", ifc.in_ready, 1);
    chk("release_out_valid", ifc.out_valid, 0);
    send(8'd50, 8'd1, 8'd2, 8'd3, 16'd220, 1'b0, 1'b1);
    drain();

    // Overflow with full-scale coefficients and samples.
    do_reset();
    send(8'd255, 8'd255, 8'd255, 8'd255, 16'd65025, 1'b0, 1'b1);
    send(8'd255, 8'd255, 8'd255, 8'd255, OVF_Y2, 1'b1, 1'b1);
    send(8'd255, 8'd255, 8'd255, 8'd255, OVF_Y3, 1'b1, 1'b1);
    drain();

    // Reset during ACC1 discards the sample.
    send(8'd7, 8'd1, 8'd1, 8'd1, 16'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", ifc.out_valid, 0);
    chk("midrst_in_ready", ifc.in_ready, 1);
    rst = 1'b0;
    send(8'd5, 8'd1, 8'd0, 8'd0, 16'd5, 1'b0, 1'b1);
    drain();

    // Back-to-back: one accept every 5 cycles, outputs in order.
    send(8'd1, 8'd1, 8'd1, 8'd1, 16'd6, 1'b0, 1'b1);
    b2b = 1'b1;
    send(8'd2, 8'd1, 8'd1, 8'd1, 16'd8, 1'b0, 1'b1);
    send(8'd3, 8'd1, 8'd1, 8'd1, 16'd6, 1'b0, 1'b1);
    send(8'd4, 8'd1, 8'd1, 8'd1, 16'd9, 1'b0, 1'b1);
    b2b = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fir3_serial_mac.md
# fir3_serial_mac

Three-tap FIR datapath computing y[n] = c0·x[n] + c1·x[n−1] + c2·x[n−2]. It holds the sample delay line, forms the tap products and time-multiplexes one 16-bit carry-skip adder across the three taps. It is the stage directly upstream of the adder: it feeds the adder's operands each cycle and consumes its sum and carry back into the accumulator. The upstream sample source connects over a valid/ready handshake, and so does the downstream consumer.

## Interface
- DATA_W, 8, sample width (unsigned)
- COEF_W, 8, coefficient width (unsigned); DATA_W + COEF_W must equal 16
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_sample is valid
- in_ready  output  1  block can accept a sample
- in_sample  input  DATA_W  new sample x[n]
- coef0, coef1, coef2  input  COEF_W each  tap coefficients, sampled at accept
- out_valid  output  1  out_y/out_ovf are valid
- out_ready  input  1  consumer takes the result
- out_y  output  16  filter output
- out_ovf  output  1  an accumulate carried out of bit 15 for this output

## Operation
- States: IDLE, ACC0, ACC1, ACC2, OUT.
- IDLE
  - in_ready=1.
  - On in_valid: shift x2<=x1, x1<=x0, x0<=in_sample.
  - Latch coef0..2; clear acc and ovf; go to ACC0.
- ACC0/ACC1/ACC2
  - Adder operands: a=acc, b=coefK·xK (full 16-bit unsigned product).
  - acc<=sum; ovf<=ovf|carry; advance to the next state. ACC2 goes to OUT.
- OUT
  - out_valid=1; out_y=acc; out_ovf=ovf.
  - On out_ready, go to IDLE. Otherwise hold.
- in_ready=0 in every state except IDLE. in_valid while busy is ignored, and the upstream source must hold its sample.
- Arithmetic is unsigned modulo 2^16, except as modified by the configuration macro.
- rst clears x0..x2, acc, ovf and coefficient registers to 0, and forces IDLE.
  - rst takes priority over every handshake.
  - rst mid-computation (any ACCk or OUT) discards the partial result; no output is produced for that sample.
- The first two outputs after reset use zero history.

## Timing
- Reset values: in_ready=1, out_valid=0, out_y=0, out_ovf=0.
- Accept at edge T (in_valid & in_ready). ACC0, ACC1 and ACC2 occupy the cycles after T, T+1 and T+2. out_valid is high from the cycle after edge T+3.
- Latency is 3 cycles from accept to out_valid.
- Minimum sample period is 5 cycles: IDLE, ACC0, ACC1, ACC2, OUT with out_ready=1.
- out_y and out_ovf are registered and stay stable while out_valid=1 and out_ready=0.
- The adder is combinational inside one cycle. The product and the adder path form the critical path.

## Configuration
- FIR3_OVF_SAT_EN defined:
  - On any carry, acc loads 16'hFFFF.
  - acc remains 16'hFFFF for the rest of that sample. A later sum that carries, or does not, still leaves it at 16'hFFFF.
  - out_ovf=1.
- Undefined:
  - acc wraps modulo 2^16.
  - out_ovf still reports the carry.

## Structure
- fir3_pkg holds:
  - state enum (IDLE, ACC0, ACC1, ACC2, OUT)
  - DATA_W, COEF_W, ACC_W=16 constants
  - the 16'hFFFF saturation constant
- One sub-module: carryskipadder (a[15:0], b[15:0] -> sum[15:0], carry), instantiated once as the shared accumulate adder.
- The product mux and the FSM stay in the top module.

## Test plan
- Zero history: after reset, coefs 1,2,3, sample 10 -> out_y=10, out_ovf=0, out_valid 3 cycles after accept.
- Delay line: continuing with samples 20 then 30 -> out_y=40, then 100.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in OUT -> out_y stable, in_ready=0.
  - in_valid pulses during this window are not accepted.
  - Release -> IDLE the next cycle.
- Overflow: coefs 255,255,255, samples 255,255,255 -> third output.
  - Macro undefined: out_y=16'hFA03, out_ovf=1.
  - FIR3_OVF_SAT_EN defined: out_y=16'hFFFF, out_ovf=1.
  - First output for the same stimulus: out_y=65025, out_ovf=0.
- Reset mid-op:
  - Assert rst in ACC1 -> next cycle out_valid=0, in_ready=1, no stale output.
  - Then coefs 1,0,0, sample 5 -> out_y=5.
- Back-to-back throughput: in_valid and out_ready held high -> one accept every 5 cycles, with outputs in order.
